// File: rtl/dwconv_bias_buffer_pp_if.sv
// -----------------------------------------------------------------------------
// dwconv_bias_buffer_pp_if
// Handshake / bus bundle for the per-channel bias store.
//   master : upstream loader + MAC-array read side (drives load/read/swap)
//   slave  : the bias buffer itself
// Signals:
//   load_en      loader done, loading may begin while high
//   in_valid     bias word valid
//   in_data      bias word (word k targets channel k)
//   in_ready     buffer accepts in_data this cycle
//   reload       pulse: discard write progress, return to IDLE
//   load_done    write bank holds all CH words
//   r_en         read strobe
//   bias_out     all CH biases, channel i at [DW*i +: DW]
//   bias_valid   one-cycle pulse, bias_out updated
//   swap         pulse: exchange banks (ping-pong build only)
//   active_bank  bank driving reads
// -----------------------------------------------------------------------------
interface dwconv_bias_buffer_pp_if #(
  parameter int CH = 32,
  parameter int DW = 16
);
  logic            load_en;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            in_ready;
  logic            reload;
  logic            load_done;
  logic            r_en;
  logic [CH*DW-1:0] bias_out;
  logic            bias_valid;
  logic            swap;
  logic            active_bank;

  modport master (
    output load_en, in_valid, in_data, reload, r_en, swap,
    input  in_ready, load_done, bias_out, bias_valid, active_bank
  );

  modport slave (
    input  load_en, in_valid, in_data, reload, r_en, swap,
    output in_ready, load_done, bias_out, bias_valid, active_bank
  );
endinterface

// File: rtl/dwconv_bias_buffer_pp.sv
// -----------------------------------------------------------------------------
// dwconv_bias_buffer_pp
// Per-channel bias register file for the convolution layers. Bias words stream
// in serially (valid/ready) into the write bank; a read strobe loads all CH
// biases in parallel onto bias_out one cycle later.
//
// Build option: define BIAS_BUF_PINGPONG_EN for two banks (load into the
// inactive bank while the active bank is read, exchanged by swap while FULL).
// Without it there is a single shared bank, swap is ignored, active_bank=0.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous reset, ACTIVE-HIGH despite the name (1 = reset)
//   bus    dwconv_bias_buffer_pp_if.slave (see interface header)
// -----------------------------------------------------------------------------
module dwconv_bias_buffer_pp #(
  parameter int CH = 32,
  parameter int DW = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dwconv_bias_buffer_pp_if.slave  bus
);
  localparam int CW = $clog2(CH);
`ifdef BIAS_BUF_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  localparam logic [CW-1:0] LAST_IDX = CW'(CH - 1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_idx;
  logic [DW-1:0]    r_mem [NB][CH];
  logic [CH*DW-1:0] r_bias_out;
  logic             r_bias_valid;

  logic             w_accept;
  logic             w_swap_go;
  logic             w_wbank;
  logic             w_rbank;

  // reload outranks an accept: the word presented in the reload cycle is dropped.
  assign w_accept = (r_state == S_LOAD) && bus.in_valid && !bus.reload;

`ifdef BIAS_BUF_PINGPONG_EN
  logic r_active_bank;

  assign w_swap_go = bus.swap && (r_state == S_FULL) && !bus.reload;
  assign w_wbank   = ~r_active_bank;
  assign w_rbank   = r_active_bank;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_active_bank <= 1'b0;
    end else if (w_swap_go) begin
      r_active_bank <= ~r_active_bank;
    end
  end
`else
  logic w_unused_swap;

  assign w_unused_swap = bus.swap;
  assign w_swap_go     = 1'b0;
  assign w_wbank       = 1'b0;
  assign w_rbank       = 1'b0;
`endif

  // Write-side FSM and channel index.
  // NOTE: every clocked block uses non-blocking (<=) so all state updates see
  // pre-edge values, which is what makes the same-cycle read return old data.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else if (bus.reload) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_idx <= '0;
          if (bus.load_en) r_state <= S_LOAD;
        end
        // load_en dropping here does not abort; only reload leaves LOAD early.
        S_LOAD: begin
          if (w_accept) begin
            if (r_idx == LAST_IDX) begin
              r_idx   <= '0;
              r_state <= S_FULL;
            end else begin
              r_idx <= r_idx + CW'(1);
            end
          end
        end
        S_FULL: begin
          if (w_swap_go) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bias register file.
  // NOTE: the storage is reset on purpose: unwritten channels must read as 0
  // after reset, so this cannot be mapped to an un-resettable RAM macro.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int b = 0; b < NB; b++) begin
        for (int i = 0; i < CH; i++) begin
          r_mem[b][i] <= '0;
        end
      end
    end else if (w_accept) begin
      r_mem[w_wbank][r_idx] <= bus.in_data;
    end
  end

  // Parallel read: whole bank copied onto bias_out in one register load.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_bias_out   <= '0;
      r_bias_valid <= 1'b0;
    end else begin
      r_bias_valid <= bus.r_en;
      if (bus.r_en) begin
        for (int i = 0; i < CH; i++) begin
          r_bias_out[DW*i +: DW] <= r_mem[w_rbank][i];
        end
      end
    end
  end

  assign bus.in_ready    = (r_state == S_LOAD);
  assign bus.load_done   = (r_state == S_FULL);
  assign bus.bias_out    = r_bias_out;
  assign bus.bias_valid  = r_bias_valid;
  assign bus.active_bank = w_rbank;

endmodule

// File: tb/tb_dwconv_bias_buffer_pp.sv
// -----------------------------------------------------------------------------
// tb_dwconv_bias_buffer_pp
// Self-checking bench for dwconv_bias_buffer_pp (CH=32, DW=16). Compares the
// DUT every cycle against a word-count based reference model, plus a vector
// table, hand-written corner sequences and a randomized phase. Works in both
// the default and the BIAS_BUF_PINGPONG_EN build.
// -----------------------------------------------------------------------------
module tb_dwconv_bias_buffer_pp;
  localparam int CH = 32;
  localparam int DW = 16;
  localparam int W  = CH * DW;
`ifdef BIAS_BUF_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  typedef logic [W-1:0] wide_t;

  typedef struct {
    bit            le;
    bit            iv;
    bit            rl;
    bit            re;
    bit            sw;
    logic [DW-1:0] d;
    bit            exp_ready;
    bit            exp_done;
    bit            exp_valid;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dwconv_bias_buffer_pp_if #(.CH(CH), .DW(DW)) bus ();

  dwconv_bias_buffer_pp #(.CH(CH), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;

  // Reference model: contents per bank, words accepted in the current load,
  // whether a load has been started, and the held read output.
  logic [DW-1:0] m_mem [2][CH];
  bit            m_act;
  bit            m_started;
  int            m_count;
  bit            m_valid;
  wide_t         m_bias;

  task automatic check(input string name, input wide_t act, input wide_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < CH; i++) m_mem[b][i] = '0;
    m_act     = 1'b0;
    m_started = 1'b0;
    m_count   = 0;
    m_valid   = 1'b0;
    m_bias    = '0;
  endtask

  task automatic model_step(input bit le, iv, rl, re, sw, input logic [DW-1:0] d);
    int wb;
    wb = PP ? int'(!m_act) : 0;
    m_valid = re;
    if (re)
      for (int i = 0; i < CH; i++) m_bias[DW*i +: DW] = m_mem[int'(m_act)][i];
    if (rl) begin
      m_started = 1'b0;
      m_count   = 0;
    end else if (!m_started) begin
      m_started = le;
      m_count   = 0;
    end else if (m_count < CH) begin
      if (iv) begin
        m_mem[wb][m_count] = d;
        m_count++;
      end
    end else if (PP && sw) begin
      m_act     = !m_act;
      m_started = 1'b0;
      m_count   = 0;
    end
  endtask

  task automatic compare_all();
    check("in_ready",    wide_t'(bus.in_ready),    wide_t'(m_started && (m_count < CH)));
    check("load_done",   wide_t'(bus.load_done),   wide_t'(m_started && (m_count == CH)));
    check("bias_valid",  wide_t'(bus.bias_valid),  wide_t'(m_valid));
    check("active_bank", wide_t'(bus.active_bank), wide_t'(m_act));
    check("bias_out",    bus.bias_out,             m_bias);
  endtask

  task automatic drive_idle();
    bus.load_en  = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.reload   = 1'b0;
    bus.r_en     = 1'b0;
    bus.swap     = 1'b0;
  endtask

  // One clock: drive on negedge, advance model, check #1 after the posedge.
  task automatic tick(input bit le, iv, rl, re, sw, input logic [DW-1:0] d);
    @(negedge clk);
    bus.load_en  = le;
    bus.in_valid = iv;
    bus.in_data  = d;
    bus.reload   = rl;
    bus.r_en     = re;
    bus.swap     = sw;
    if (bus.in_ready && iv && !rl) n_acc++;
    model_step(le, iv, rl, re, sw, d);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic start_load();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic load_words(input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, base + DW'(k));
  endtask

  function automatic vec_t mk(input bit le, iv, rl, re, sw, input logic [DW-1:0] d,
                              input bit er, ed, ev);
    vec_t v;
    v.le = le; v.iv = iv; v.rl = rl; v.re = re; v.sw = sw; v.d = d;
    v.exp_ready = er; v.exp_done = ed; v.exp_valid = ev;
    return v;
  endfunction

  initial begin
    vec_t vt [8];
    int   cyc;

    vt[0] = mk(0, 0, 0, 1, 0, 16'h0000, 0, 0, 1);  // read right after reset
    vt[1] = mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0);  // bias_valid is a pulse
    vt[2] = mk(1, 0, 0, 0, 0, 16'h0000, 1, 0, 0);  // load_en -> LOAD next cycle
    vt[3] = mk(0, 0, 0, 0, 0, 16'h0000, 1, 0, 0);  // load_en drop keeps LOAD
    vt[4] = mk(0, 1, 0, 0, 0, 16'h0055, 1, 0, 0);  // one accept
    vt[5] = mk(0, 1, 1, 0, 0, 16'h0066, 0, 0, 0);  // reload beats accept
    vt[6] = mk(0, 0, 0, 1, 0, 16'h0000, 0, 0, 1);
    vt[7] = mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0);

    // ---- reset values ----
    drive_idle();
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_in_ready",   wide_t'(bus.in_ready),    '0);
    check("rst_load_done",  wide_t'(bus.load_done),   '0);
    check("rst_bias_valid", wide_t'(bus.bias_valid),  '0);
    check("rst_bias_out",   bus.bias_out,             '0);
    check("rst_active",     wide_t'(bus.active_bank), '0);
    rst_n = 1'b0;

    // ---- vector table ----
    for (int i = 0; i < 8; i++) begin
      tick(vt[i].le, vt[i].iv, vt[i].rl, vt[i].re, vt[i].sw, vt[i].d);
      check($sformatf("vec%0d_ready", i), wide_t'(bus.in_ready),   wide_t'(vt[i].exp_ready));
      check($sformatf("vec%0d_done", i),  wide_t'(bus.load_done),  wide_t'(vt[i].exp_done));
      check($sformatf("vec%0d_valid", i), wide_t'(bus.bias_valid), wide_t'(vt[i].exp_valid));
    end

    // ---- full load 1..32, in_valid toggling ----
    n_acc = 0;
    cyc   = 0;
    while (!(m_started && m_count == CH) && cyc < 200) begin
      tick(1'b1, cyc[0], 1'b0, 1'b0, 1'b0, DW'(m_count + 1));
      cyc++;
    end
    check("stream_accepts",  wide_t'(n_acc),         wide_t'(CH));
    check("stream_done",     wide_t'(bus.load_done), wide_t'(1));
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
`ifndef BIAS_BUF_PINGPONG_EN
    check("stream_ch0",  wide_t'(bus.bias_out[15:0]),    wide_t'(16'h0001));
    check("stream_ch31", wide_t'(bus.bias_out[511:496]), wide_t'(16'h0020));
`endif

    // ---- extra words while FULL are ignored ----
    n_acc = 0;
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hDEAD);
    check("full_no_accept", wide_t'(n_acc), '0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);

`ifndef BIAS_BUF_PINGPONG_EN
    // ---- same-cycle write/read, then reload mid-LOAD ----
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    start_load();
    load_words(3, 16'h0001);
    tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h7FFF);
    check("rw_old_ch3", wide_t'(bus.bias_out[3*DW +: DW]), wide_t'(16'h0004));
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("rw_new_ch3", wide_t'(bus.bias_out[3*DW +: DW]), wide_t'(16'h7FFF));
    load_words(6, 16'h0005);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF);
    start_load();
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hABCD);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("reload_ch0",  wide_t'(bus.bias_out[0 +: DW]),     wide_t'(16'hABCD));
    check("reload_ch10", wide_t'(bus.bias_out[10*DW +: DW]), wide_t'(16'h000B));
`else
    // ---- ping-pong: fill bank 1, swap, refill bank 0, swap again ----
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    start_load();
    load_words(CH, 16'h1000);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("pp_active1", wide_t'(bus.active_bank), wide_t'(1));
    check("pp_done0",   wide_t'(bus.load_done),   '0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("pp_b1_ch0",  wide_t'(bus.bias_out[0 +: DW]),      wide_t'(16'h1000));
    check("pp_b1_ch31", wide_t'(bus.bias_out[31*DW +: DW]),  wide_t'(16'h101F));
    start_load();
    load_words(CH, 16'h2000);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("pp_hold_ch0", wide_t'(bus.bias_out[0 +: DW]), wide_t'(16'h1000));
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
    check("pp_swap_rd",  wide_t'(bus.bias_out[0 +: DW]), wide_t'(16'h1000));
    check("pp_active0",  wide_t'(bus.active_bank),       '0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("pp_b0_ch5",   wide_t'(bus.bias_out[5*DW +: DW]), wide_t'(16'h2005));
`endif

    // ---- asynchronous reset mid-stream after 17 words ----
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    start_load();
    load_words(17, 16'h0100);
    #2;
    drive_idle();
    rst_n = 1'b1;
    #1;
    check("arst_in_ready",   wide_t'(bus.in_ready),    '0);
    check("arst_load_done",  wide_t'(bus.load_done),   '0);
    check("arst_bias_valid", wide_t'(bus.bias_valid),  '0);
    check("arst_bias_out",   bus.bias_out,             '0);
    check("arst_active",     wide_t'(bus.active_bank), '0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("arst_read_zero", bus.bias_out, '0);

    // ---- randomized traffic against the model ----
    for (int k = 0; k < 600; k++) begin
      tick($urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 149) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 7) == 0,
           DW'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dwconv_bias_buffer_pp.md
# dwconv_bias_buffer_pp

Parametrised per-channel bias store for the convolution layers. Bias words stream in serially over a valid/ready handshake once the upstream loader enables it, and are held in a CH-entry register file. A read strobe presents all CH biases in parallel to the MAC array one cycle later. An optional second bank lets the next layer's biases load while the current layer's biases are being consumed.

## Interface
- CH, 32: number of bias channels (entries); 2..256.
- DW, 16: bias word width in bits (signed fixed-point, stored verbatim).
- CW, $clog2(CH): write-index counter width (derived).
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-high, so rst_n=1 resets the block.
- load_en  in  1  level; upstream loader done (e.g. previous layer's weights/biases loaded); loading may begin while high.
- in_valid  in  1  bias word valid.
- in_data  in  DW  bias word; word k targets channel k.
- in_ready  out  1  block accepts in_data this cycle.
- reload  in  1  pulse; discard write progress and return to IDLE.
- load_done  out  1  level; the write bank holds all CH words.
- r_en  in  1  read strobe.
- bias_out  out  CH*DW  channel i at bits [DW*i+DW-1 : DW*i].
- bias_valid  out  1  one-cycle pulse; bias_out updated.
- swap  in  1  pulse; ping-pong only (ignored otherwise).
- active_bank  out  1  bank driving reads; constant 0 without ping-pong.

## Operation
- Write FSM states: IDLE, LOAD, FULL.
- IDLE: in_ready=0. Moves to LOAD when load_en=1. Index resets to 0.
- LOAD: in_ready=1. On accept (in_valid&&in_ready), mem[wbank][idx]<=in_data and idx increments. On the accept with idx==CH-1, the FSM goes to FULL, idx goes to 0 and load_done goes to 1 in the next cycle.
- FULL: in_ready=0 and load_done=1. Extra in_valid is ignored: no write and no wrap-around overwrite.
- A load_en drop during LOAD does not abort the load; the FSM stays in LOAD.
- reload in any state: next state IDLE, idx=0, load_done=0. Memory contents are retained. reload has priority over an accept in the same cycle, and that word is not written.
- Read: on r_en, bias_out<=mem[active_bank][0..CH-1] as one register load, and bias_valid=1 in the next cycle. Without r_en, bias_out holds its value.
- r_en is honoured in every FSM state. Entries not yet written read as 0 (post-reset) or as the previous contents.
- Same-cycle write and read of the same bank/entry: bias_out receives the old value.

## Timing
- Reset values: all mem entries 0, bias_out=0, bias_valid=0, in_ready=0, load_done=0, active_bank=0, FSM=IDLE, idx=0.
- load_en rising to first possible accept: 1 cycle (IDLE->LOAD, then in_ready high).
- Full load: CH accepting cycles minimum. load_done rises the cycle after the CH-th accept.
- Read latency: exactly 1 cycle from r_en to bias_out/bias_valid. Back-to-back r_en gives bias_valid held high.
- Reset asserted mid-load or mid-read clears everything immediately (asynchronously). Any partial load is lost.

## Configuration
- BIAS_BUF_PINGPONG_EN defined:
  - Two banks. Loads write bank ~active_bank. Reads use active_bank.
  - swap while FSM=FULL: active_bank toggles, FSM goes to IDLE, load_done goes to 0, all next cycle. A new load then targets the freed bank.
  - swap while not FULL is ignored.
  - swap and r_en in the same cycle: the read uses the pre-swap bank.
  - reload and swap in the same cycle: reload wins and there is no toggle.
- BIAS_BUF_PINGPONG_EN undefined:
  - Single bank, shared by reads and writes. swap is ignored and active_bank=0.
  - Leaving FULL requires reload.

## Test plan
- Reset, then r_en -> next cycle bias_out=0 and bias_valid=1 for one cycle; in_ready=0 and load_done=0.
- CH=32, DW=16: load_en=1, stream 0x0001..0x0020 with in_valid toggling every other cycle -> exactly 32 accepts, load_done high the cycle after the last accept. r_en then gives channel i = i+1 (e.g. bits[15:0]=0x0001, bits[511:496]=0x0020).
- After FULL, drive 5 more valid words -> no accepts, in_ready=0, contents unchanged. reload mid-LOAD after 10 words -> idx restarts, and the next word lands in channel 0.
- r_en in the same cycle as the write of channel 3 = 0x7FFF (old value 0x0004) -> bias_out channel 3 = 0x0004. A second r_en gives 0x7FFF.
- With BIAS_BUF_PINGPONG_EN: fill bank 1 with 0x1000+i, then swap:
  - active_bank goes to 1 and load_done to 0;
  - r_en returns 0x1000+i;
  - loading 0x2000+i into bank 0 leaves reads at 0x1000+i until a second swap.
- Assert rst_n=1 for 1 cycle asynchronously, mid-stream after 17 words -> all outputs return to reset values with no clock edge needed, and a later r_en returns all zeros.
